lbp_scan_ctrl: RTL and testbench
================================

// Module: lbp_scan_ctrl
// PURPOSE
//  Scan sequencer for the LBP engine on a 128x128 grayscale image.
//  It walks the interior pixels in raster order and issues gray-memory reads as 3-pixel columns.
//  It drives the load and shift strobes of the 3x3 window datapath, then writes each returned code to the LBP memory.
//  Border pixels are never written; the LBP memory is pre-zeroed. Raises finish after the last interior write.
// PARAMETERS
//  IMG_W   128  image width and height in pixels (square image)
//  ADDR_W  14   address width; log2(IMG_W*IMG_W)
// PORTS
//  clk         in   1       system clock, rising-edge
//  reset       in   1       asynchronous, active-low reset
//  gray_ready  in   1       gray memory available; 0 = stall
//  gray_req    out  1       read request to gray memory
//  gray_addr   out  ADDR_W  read address, row*IMG_W+col
//  dp_load     out  1       datapath captures gray_data into the window's right column
//  dp_slot     out  2       target row of the right column: 0=top, 1=mid, 2=bottom
//  dp_shift    out  1       shift window one column left; same cycle as slot-0 load
//  dp_code     in   8       LBP code from the datapath, combinational from window registers
//  lbp_valid   out  1       write strobe to LBP memory; memory samples on negedge clk
//  lbp_addr    out  ADDR_W  write address, r*IMG_W+c
//  lbp_data    out  8       write data; equals dp_code while lbp_valid=1
//  finish      out  1       image done; sticky until reset
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, r=1, c=1, col=0.
//   All outputs are 0: gray_req, gray_addr, dp_*, lbp_valid, lbp_addr, lbp_data, finish.
//  Read timing: gray_data is valid within the cycle gray_req=1 and is captured at that cycle's closing posedge.
//   dp_load therefore equals gray_req. Zero read latency; one pixel per cycle.
//  States:
//   IDLE:  wait for gray_ready=1, then go to PRIME.
//   PRIME: read columns 0 and 1 of rows r-1..r+1 (6 cycles, slot order 0,1,2 per column). Then go to FETCH.
//   FETCH: read column c+1 of rows r-1..r+1 (3 cycles). Then go to WRITE.
//   WRITE: one cycle with lbp_valid=1, lbp_addr=r*IMG_W+c, lbp_data=dp_code, gray_req=0.
//     If c<IMG_W-2: c++ and go to FETCH.
//     Else if r<IMG_W-2: r++, c=1, go to PRIME.
//     Else go to DONE.
//   DONE:  finish=1; all other outputs 0; stays here until reset.
//  dp_shift=1 on every slot-0 fetch cycle in PRIME and FETCH. The window then holds columns c-1..c+1 at WRITE.
//  Per interior pixel: 4 cycles. Per row: 6 + 4*(IMG_W-2) cycles.
//  Total for IMG_W=128: 126*510 = 64260 cycles from leaving IDLE to entering DONE.
//  Stall: gray_ready=0 in PRIME or FETCH forces gray_req=0 and dp_load/dp_shift=0.
//   State, counters and slot all freeze; the scan resumes at the same address.
//   WRITE does not depend on gray_ready.
//  Addresses: computed as {r,7'b0}+c, shift-add, no multiplier. Counters never exceed IMG_W-1.
//  Reset mid-scan: abort immediately to IDLE with the reset values. A partial image is not resumed.
// STRUCTURE
//  Shared package lbp_pkg: IMG_W, ADDR_W, state enum (IDLE, PRIME, FETCH, WRITE, DONE).
//  One sub-module, lbp_addr_gen: holds the r/c/slot counters and forms gray_addr and lbp_addr.
//  The FSM stays in lbp_scan_ctrl.
// TESTING
//  1. Reset held, gray_ready=1 -> all outputs 0. On release, the first gray_addr sequence is
//     0,128,256,1,129,257,2,130,258; dp_shift is 1 on addresses 0, 1 and 2.
//  2. dp_code forced to 8'hA5 -> first write is lbp_valid=1, lbp_addr=129, lbp_data=A5, one cycle after addr 258.
//  3. gray_ready dropped for 5 cycles right after addr 129 -> gray_req=0 for those 5 cycles, then addr 257 is reissued.
//     lbp_addr=129 is then written exactly once.
//  4. Full image run -> 15876 writes in total. Last lbp_addr is 16254 (126*128+126).
//     finish rises the cycle after that write; DONE is entered 64260 cycles after IDLE exit.
//  5. Row turnover -> after lbp_addr=254, the next reads are 128,256,384,129,257,385,130,258,386 (PRIME of r=2).
//  6. reset=0 asserted mid-row (r=40) -> outputs are 0 asynchronously. After release, the scan restarts at addr 0.
//     finish never rises early.

Source files
------------

// File: rtl/lbp_scan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// lbp_pkg
// Shared constants and types for the LBP scan sequencer.
//   IMG_W  : image width/height in pixels (square image)
//   CNT_W  : width of one row/column index, log2(IMG_W)
//   ADDR_W : pixel address width, 2*CNT_W (address = row*IMG_W + col)
//   state_e: scan controller states
// ---------------------------------------------------------------------------
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int CNT_W  = 7;
  localparam int ADDR_W = 2 * CNT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    FETCH = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage : lbp_pkg

// File: rtl/lbp_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// lbp_scan_ctrl_if
// Bundles the gray-memory read port, the 3x3 window datapath strobes and the
// LBP-memory write port of the scan sequencer.
//   master : the scan controller (drives requests, strobes, writes, finish)
//   slave  : memories/datapath side (drives gray_ready and dp_code)
// Signals:
//   gray_ready  memory available (0 = stall)      gray_req/gray_addr  read port
//   dp_load/dp_slot/dp_shift  window strobes      dp_code             LBP code
//   lbp_valid/lbp_addr/lbp_data  write port       finish              image done
// ---------------------------------------------------------------------------
interface lbp_scan_ctrl_if;

  logic                      gray_ready;
  logic                      gray_req;
  logic [lbp_pkg::ADDR_W-1:0] gray_addr;
  logic                      dp_load;
  logic [1:0]                dp_slot;
  logic                      dp_shift;
  logic [7:0]                dp_code;
  logic                      lbp_valid;
  logic [lbp_pkg::ADDR_W-1:0] lbp_addr;
  logic [7:0]                lbp_data;
  logic                      finish;

  modport master (
    input  gray_ready, dp_code,
    output gray_req, gray_addr, dp_load, dp_slot, dp_shift,
           lbp_valid, lbp_addr, lbp_data, finish
  );

  modport slave (
    output gray_ready, dp_code,
    input  gray_req, gray_addr, dp_load, dp_slot, dp_shift,
           lbp_valid, lbp_addr, lbp_data, finish
  );

endinterface : lbp_scan_ctrl_if

// File: rtl/lbp_scan_ctrl_addr_gen.sv
// ---------------------------------------------------------------------------
// lbp_addr_gen
// Holds the scan counters (centre row r, centre column c, window slot and the
// prime-column index) and forms the gray-memory read address and the
// LBP-memory write address with shift-add (no multiplier).
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   rd_fire_i      a gray read is issued this cycle (advances slot/col)
//   prime_i        controller is priming columns c-1 and c
//   adv_col_i      move to the next centre column (c++)
//   adv_row_i      move to the next centre row (r++, c=1)
//   slot_o         window row of the current read (0=top..2=bottom)
//   slot_last_o    current read is the bottom pixel of its column
//   col_last_o     priming the second column
//   c_last_o       c is the last interior column
//   r_last_o       r is the last interior row
//   rd_addr_o      read address (r-1+slot)*IMG_W + column
//   wr_addr_o      write address r*IMG_W + c
// ---------------------------------------------------------------------------
module lbp_addr_gen
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_fire_i,
  input  logic              prime_i,
  input  logic              adv_col_i,
  input  logic              adv_row_i,
  output logic [1:0]        slot_o,
  output logic              slot_last_o,
  output logic              col_last_o,
  output logic              c_last_o,
  output logic              r_last_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IMG_W - 2);

  logic [CNT_W-1:0] r_q;
  logic [CNT_W-1:0] c_q;
  logic [1:0]       slot_q;
  logic             col_q;

  logic [CNT_W-1:0] rd_row;
  logic [CNT_W-1:0] rd_col;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q    <= CNT_W'(1);
      c_q    <= CNT_W'(1);
      slot_q <= 2'd0;
      col_q  <= 1'b0;
    end else begin
      if (rd_fire_i) begin
        if (slot_q == 2'd2) begin
          slot_q <= 2'd0;
          // Priming walks column c-1 then c; the toggle leaves col_q at 0
          // again once the second column is done.
          if (prime_i) col_q <= ~col_q;
        end else begin
          slot_q <= slot_q + 2'd1;
        end
      end
      if (adv_row_i) begin
        r_q <= r_q + CNT_W'(1);
        c_q <= CNT_W'(1);
      end else if (adv_col_i) begin
        c_q <= c_q + CNT_W'(1);
      end
    end
  end

  // Priming starts at c=1, so its two columns are simply 0 and 1; a regular
  // fetch brings in the column right of the centre.
  assign rd_row = r_q - CNT_W'(1) + CNT_W'(slot_q);
  assign rd_col = prime_i ? CNT_W'(col_q) : c_q + CNT_W'(1);

  assign rd_addr_o   = {rd_row, {CNT_W{1'b0}}} + ADDR_W'(rd_col);
  assign wr_addr_o   = {r_q, {CNT_W{1'b0}}} + ADDR_W'(c_q);

  assign slot_o      = slot_q;
  assign slot_last_o = (slot_q == 2'd2);
  assign col_last_o  = col_q;
  assign c_last_o    = (c_q == LAST_IDX);
  assign r_last_o    = (r_q == LAST_IDX);

endmodule : lbp_addr_gen

// File: rtl/lbp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// lbp_scan_ctrl
// Scan sequencer for the LBP engine. Walks the interior pixels of an
// IMG_W x IMG_W image in raster order, reads 3-pixel columns from the gray
// memory into the 3x3 window datapath and writes each returned LBP code to
// the LBP memory. Border pixels are never written. finish is sticky.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   bus    lbp_scan_ctrl_if.master: gray read port, window strobes,
//          LBP write port and finish
// Timing: zero-latency reads, so dp_load equals gray_req. Each interior
// pixel costs 3 fetch cycles + 1 write cycle; each row adds 6 prime cycles.
// ---------------------------------------------------------------------------
module lbp_scan_ctrl
  import lbp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  lbp_scan_ctrl_if.master  bus
);

  state_e state_q;
  logic   finish_q;

  logic              in_read;
  logic              in_write;
  logic              rd_fire;
  logic              adv_col;
  logic              adv_row;
  logic [1:0]        slot;
  logic              slot_last;
  logic              col_last;
  logic              c_last;
  logic              r_last;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  // A stall only gates reads; the write cycle proceeds regardless.
  assign in_read  = (state_q == PRIME) || (state_q == FETCH);
  assign in_write = (state_q == WRITE);
  assign rd_fire  = in_read && bus.gray_ready;
  assign adv_col  = in_write && !c_last;
  assign adv_row  = in_write && c_last && !r_last;

  lbp_addr_gen u_addr_gen (
    .clk         (clk),
    .reset       (reset),
    .rd_fire_i   (rd_fire),
    .prime_i     (state_q == PRIME),
    .adv_col_i   (adv_col),
    .adv_row_i   (adv_row),
    .slot_o      (slot),
    .slot_last_o (slot_last),
    .col_last_o  (col_last),
    .c_last_o    (c_last),
    .r_last_o    (r_last),
    .rd_addr_o   (rd_addr),
    .wr_addr_o   (wr_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      finish_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (bus.gray_ready) state_q <= PRIME;
        PRIME: if (rd_fire && slot_last && col_last) state_q <= FETCH;
        FETCH: if (rd_fire && slot_last) state_q <= WRITE;
        WRITE: begin
          if (!c_last) begin
            state_q <= FETCH;
          end else if (!r_last) begin
            state_q <= PRIME;
          end else begin
            state_q  <= DONE;
            finish_q <= 1'b1;
          end
        end
        DONE:    state_q <= DONE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; addresses and data are forced to
  // zero outside their strobe so idle/stall/done cycles drive all zeros.
  assign bus.gray_req  = rd_fire;
  assign bus.gray_addr = rd_fire ? rd_addr : '0;
  assign bus.dp_load   = rd_fire;
  assign bus.dp_slot   = rd_fire ? slot : 2'd0;
  assign bus.dp_shift  = rd_fire && (slot == 2'd0);
  assign bus.lbp_valid = in_write;
  assign bus.lbp_addr  = in_write ? wr_addr : '0;
  assign bus.lbp_data  = in_write ? bus.dp_code : 8'd0;
  assign bus.finish    = finish_q;

endmodule : lbp_scan_ctrl

// File: tb/tb_lbp_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lbp_scan_ctrl
// Randomized bench for lbp_scan_ctrl. The reference model is the ordered list
// of memory events the scan must produce (every read and every write of the
// whole image, built with nested loops over rows and columns). Each cycle the
// bench picks gray_ready and dp_code at random and predicts the full output
// vector from the head of that list.
// ---------------------------------------------------------------------------
module tb_lbp_scan_ctrl;
  import lbp_pkg::*;

  localparam int N = IMG_W;

  typedef struct {
    bit is_wr;
    int addr;
    int slot;
  } ev_t;

  logic clk = 1'b0;
  logic reset;

  lbp_scan_ctrl_if bus ();

  lbp_scan_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  ev_t evq[$];
  bit  started;
  bit  arm129;
  int  stall_left;
  int  stall_cnt;
  int  wr_model;
  int  model_idx;

  int  wr_cnt;
  int  last_wr;
  int  cnt129;
  int  active_cyc;
  bit  finish_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full scan order: per centre row, prime columns 0 and 1, then for every
  // centre column fetch column c+1 (top to bottom) and write pixel (r,c).
  function automatic void build_model();
    evq.delete();
    for (int r = 1; r <= N - 2; r++) begin
      for (int col = 0; col < 2; col++)
        for (int s = 0; s < 3; s++)
          evq.push_back('{1'b0, (r - 1 + s) * N + col, s});
      for (int c = 1; c <= N - 2; c++) begin
        for (int s = 0; s < 3; s++)
          evq.push_back('{1'b0, (r - 1 + s) * N + c + 1, s});
        evq.push_back('{1'b1, r * N + c, 0});
      end
    end
  endfunction

  function automatic logic [63:0] pack_exp(input bit rd, input int raddr, input int slot,
                                           input bit wr, input int waddr,
                                           input logic [7:0] data, input bit fin);
    return {21'b0, rd, 14'(raddr), rd, 2'(slot), (rd && slot == 0),
            wr, 14'(waddr), data, fin};
  endfunction

  function automatic logic [63:0] pack_obs();
    return {21'b0, bus.gray_req, bus.gray_addr, bus.dp_load, bus.dp_slot, bus.dp_shift,
            bus.lbp_valid, bus.lbp_addr, bus.lbp_data, bus.finish};
  endfunction

  task automatic reset_tallies();
    started     = 1'b0;
    stall_left  = 0;
    stall_cnt   = 0;
    wr_model    = 0;
    model_idx   = 0;
    wr_cnt      = 0;
    last_wr     = -1;
    cnt129      = 0;
    active_cyc  = 0;
    finish_seen = 1'b0;
  endtask

  // Called at a negedge: drive inputs, predict and compare this cycle's
  // outputs, then advance to the next negedge.
  task automatic run_cycle(input int stall_pct);
    logic        rdy;
    logic [63:0] exp_v;
    ev_t         ev;
    rdy = 1'b1;
    if (stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end else if (stall_pct > 0 && $urandom_range(99, 0) < stall_pct) begin
      rdy = 1'b0;
    end
    bus.gray_ready = rdy;
    bus.dp_code    = 8'($urandom);
    #1;
    exp_v = '0;
    if (started) begin
      if (bus.finish !== 1'b1) active_cyc++;
      if (evq.size() == 0) begin
        exp_v = pack_exp(0, 0, 0, 0, 0, 8'd0, 1);
      end else if (evq[0].is_wr) begin
        ev = evq.pop_front();
        exp_v = pack_exp(0, 0, 0, 1, ev.addr, bus.dp_code, 0);
        wr_model++;
        model_idx++;
      end else if (rdy) begin
        ev = evq.pop_front();
        exp_v = pack_exp(1, ev.addr, ev.slot, 0, 0, 8'd0, 0);
        if (arm129 && ev.addr == N + 1) begin
          stall_left = 5;
          arm129     = 1'b0;
        end
        model_idx++;
      end else begin
        stall_cnt++;
      end
    end
    check($sformatf("cycle_ev%0d", model_idx), pack_obs(), exp_v);
    if (bus.lbp_valid === 1'b1) begin
      wr_cnt++;
      last_wr = int'(bus.lbp_addr);
      if (bus.lbp_addr == 14'(N + 1)) cnt129++;
    end
    if (bus.finish === 1'b1) finish_seen = 1'b1;
    if (!started && rdy) started = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int done_cycles;
    reset          = 1'b0;
    bus.gray_ready = 1'b1;
    bus.dp_code    = 8'd0;
    arm129         = 1'b0;
    reset_tallies();

    // Reset held with the memory ready: every output stays low.
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", pack_obs(), 64'd0);
    @(negedge clk);

    // Phase A: scan with random stalls in the first rows, abort at r=40.
    build_model();
    reset = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if (wr_model >= 39 * (N - 2) + 20 || errors > 20) break;
      run_cycle((wr_model < 2 * (N - 2)) ? 20 : 0);
    end
    check("reach_row40", 64'(wr_model), 64'(39 * (N - 2) + 20));
    #2 reset = 1'b0;
    #1;
    check("async_reset_outputs", pack_obs(), 64'd0);
    @(negedge clk);
    #1;
    check("reset_hold_outputs", pack_obs(), 64'd0);
    @(negedge clk);

    // Phase B: full image from scratch, including a 5-cycle stall right
    // after address 129 and random stalls near the start.
    reset_tallies();
    build_model();
    arm129      = 1'b1;
    done_cycles = 0;
    reset       = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      if (done_cycles >= 3 || errors > 20) break;
      run_cycle((model_idx < 2000) ? 10 : 0);
      if (evq.size() == 0) done_cycles++;
    end
    check("finish_seen", 64'(finish_seen), 64'd1);
    check("write_count", 64'(wr_cnt), 64'(126 * 126));
    check("last_write_addr", 64'(last_wr), 64'(126 * N + 126));
    check("addr129_writes", 64'(cnt129), 64'd1);
    check("scan_cycles", 64'(active_cyc), 64'(126 * 510 + stall_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lbp_scan_ctrl
